serial_subtractor: RTL and testbench

Bit-serial ripple-borrow subtractor computing `a - b - b_in` one bit per clock, LSB first, with a start/done handshake. It is the sequential counterpart of the combinational ripple-carry adder used in the arithmetic lab datapath, and it trades latency for a single full-subtractor cell. The block sits beside the adder and serves as the subtract path for multi-cycle arithmetic exercises.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_fs.sv | 24 ++
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_subtractor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - sub_state_t       : FSM state encoding (IDLE, SHIFT, DONE)
//   - SUB_WIDTH_DEFAULT : default operand/result width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/serial_subtractor_fs.sv
// full_subtractor
//   One-bit full subtractor cell computing a - b - br_in.
//   Ports:
//     a      in  1 : minuend bit
//     b      in  1 : subtrahend bit
//     br_in  in  1 : borrow into this bit
//     d      out 1 : difference bit
//     br_out out 1 : borrow out of this bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  logic w_p;

  assign w_p    = a ^ b;
  assign d      = w_p ^ br_in;
  // Borrow when b exceeds a outright, or when they match and a borrow ripples through.
  assign br_out = (~a & b) | (~w_p & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial ripple-borrow subtractor: diff = (a - b - b_in) mod 2^WIDTH,
//   processed LSB first, one bit per clock, with a start/done handshake.
//   Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds the signed
//   overflow output and its flop.
//   Ports:
//     clk      in  1     : clock, rising edge
//     rst_n    in  1     : asynchronous active-low reset
//     start    in  1     : request, sampled only in IDLE
//     a        in  WIDTH : minuend, captured on accept
//     b        in  WIDTH : subtrahend, captured on accept
//     b_in     in  1     : borrow-in, captured on accept
//     busy     out 1     : high in SHIFT and DONE
//     done     out 1     : one-cycle completion pulse
//     diff     out WIDTH : result, held until the next accepted start
//     b_out    out 1     : final borrow (a < b + b_in, unsigned)
//     overflow out 1     : signed overflow (only with the macro defined)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_br;

  full_subtractor u_fs (
    .a      (r_a[0]),
    .b      (r_b[0]),
    .br_in  (r_borrow),
    .d      (w_d),
    .br_out (w_br)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_borrow <= b_in;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_borrow <= w_br;
        // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
        r_res    <= {w_d, r_res[WIDTH-1:1]};
        r_cnt    <= r_cnt + 1'b1;
      end else if (r_state == DONE) begin
        r_busy   <= 1'b0;
      end
      // Outputs are loaded on the final shift so they are valid alongside done.
      if (w_last) begin
        r_diff <= {w_d, r_res[WIDTH-1:1]};
        r_bout <= w_br;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic r_ovf;

  // On the last shift r_borrow is the borrow into the MSB and w_br the borrow out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_borrow ^ w_br;
    end
  end

  assign overflow = r_ovf;
`endif

  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         overflow;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] last_diff;
  logic         last_bout;
  logic         last_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: plain integer arithmetic on the specified rules.
  function automatic int model_diff(input int ia, input int ib, input int ibin);
    int r;
    r = ia - ib - ibin;
    return ((r % (1 << W)) + (1 << W)) % (1 << W);
  endfunction

  function automatic logic model_bout(input int ia, input int ib, input int ibin);
    return (ia < ib + ibin);
  endfunction

  function automatic logic model_ovf(input int ia, input int ib, input int ibin);
    int sa, sb, r;
    sa = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
    sb = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
    r  = sa - sb - ibin;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(last_diff));
    check({tag, "_bout"}, 32'(b_out), 32'(last_bout));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(overflow), 32'(last_ovf));
`endif
  endtask

  // One full operation from IDLE; with disturb set, start and operands are
  // scrambled throughout SHIFT and DONE.
  task automatic run_op(input int ia, input int ib, input int ibin, input bit disturb);
    @(negedge clk);
    a = W'(ia); b = W'(ib); b_in = ibin[0]; start = 1'b1;
    @(posedge clk); #1;
    start = disturb;
    check("busy_accept", 32'(busy), 32'd1);
    check("done_accept", 32'(done), 32'd0);
    for (int k = 1; k <= W; k++) begin
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      end
      @(posedge clk); #1;
      check("done_timing", 32'(done), (k == W) ? 32'd1 : 32'd0);
      check("busy_run", 32'(busy), 32'd1);
    end
    last_diff = W'(model_diff(ia, ib, ibin));
    last_bout = model_bout(ia, ib, ibin);
    last_ovf  = model_ovf(ia, ib, ibin);
    check_outputs("result");
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check_outputs("hold");
    if (disturb) begin
      repeat (3) begin
        @(posedge clk); #1;
        check("no_requeue_busy", 32'(busy), 32'd0);
        check("no_requeue_done", 32'(done), 32'd0);
      end
      check_outputs("hold_disturb");
    end
  endtask

  initial begin
    int last_pulse;
    int npulse;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed subtraction cases
    run_op(5, 3, 0, 1'b0);
    check("tp1_diff", 32'(diff), 32'h2);
    check("tp1_bout", 32'(b_out), 32'h0);
    run_op(2, 5, 0, 1'b0);
    check("tp2a_diff", 32'(diff), 32'h5);
    check("tp2a_bout", 32'(b_out), 32'h1);
    run_op(0, 0, 1, 1'b0);
    check("tp2b_diff", 32'(diff), 32'h7);
    check("tp2b_bout", 32'(b_out), 32'h1);
    run_op(7, 7, 0, 1'b0);
    check("tp2c_diff", 32'(diff), 32'h0);
    check("tp2c_bout", 32'(b_out), 32'h0);

    // Start and operands disturbed during an operation
    run_op(6, 1, 0, 1'b1);

    // Reset during the second SHIFT cycle
    @(negedge clk);
    a = 3'd4; b = 3'd1; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check_outputs("midrst");
    @(posedge clk); #1;
    check("midrst_state", 32'(dut.r_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_op(4, 1, 0, 1'b0);

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    run_op(3, 5, 0, 1'b0);
    check("ovf_diff", 32'(diff), 32'h6);
    check("ovf_bout", 32'(b_out), 32'h1);
    check("ovf_set", 32'(overflow), 32'h1);
    run_op(1, 1, 0, 1'b0);
    check("ovf_clear", 32'(overflow), 32'h0);
`endif

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    // Start held high: one result every W+2 cycles, outputs stable between
    run_op(1, 0, 0, 1'b0);
    @(negedge clk);
    a = 3'd2; b = 3'd6; b_in = 1'b1; start = 1'b1;
    last_pulse = -1;
    npulse     = 0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (last_pulse >= 0) check("held_period", 32'(c - last_pulse), 32'(W + 2));
        last_pulse = c;
        npulse++;
        last_diff = W'(model_diff(2, 6, 1));
        last_bout = model_bout(2, 6, 1);
        last_ovf  = model_ovf(2, 6, 1);
      end
      check_outputs("held");
    end
    check("held_pulses", 32'(npulse), 32'd4);
    @(negedge clk);
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
